// File: rtl/arctic_seq.sv
// Arctic Circle domino-shuffling sequencer: runs the shuffle iterations, waits for
// the node mesh to settle, strobes the grid registers and supplies LFSR tie-break bits.
module arctic_seq #(
    parameter int                ORDER_W    = 5,
    parameter int                MAX_ORDER  = 16,
    parameter int                NODES      = 8,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
    parameter int                SETTLE_CYC = 2,
    parameter logic [LFSR_W-1:0] POLY       = 16'hB400
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [ORDER_W-1:0] order,
    input  logic               seed_load,
    input  logic [LFSR_W-1:0]  seed,
    output logic               busy,
    output logic               done,
    output logic               grid_clr,
    output logic               grid_en,
    output logic [NODES-1:0]   rnd,
    output logic [ORDER_W-1:0] iter
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0]   CNT_INIT    = (SETTLE_CYC > 0) ? CNT_W'(SETTLE_CYC - 1) : '0;
    localparam logic [ORDER_W-1:0] MAX_ORDER_V = ORDER_W'(MAX_ORDER);
    localparam logic [ORDER_W-1:0] ONE_V       = ORDER_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RAND,
        S_SETTLE,
        S_STEP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [ORDER_W-1:0] iter_q, iter_d;
    logic [ORDER_W-1:0] order_q, order_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LFSR_W-1:0]  lfsr_next;
    logic [ORDER_W-1:0] iter_inc;

    // Galois form, shifting right; a nonzero state can never reach zero.
    assign lfsr_next = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? POLY : '0);
    assign iter_inc  = iter_q + ONE_V;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            iter_q  <= '0;
            order_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            iter_q  <= iter_d;
            order_q <= order_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        iter_d  = iter_q;
        order_d = order_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (seed_load) begin
                    lfsr_d = (seed == '0) ? SEED : seed;
                end else if (start) begin
                    order_d = (order > MAX_ORDER_V) ? MAX_ORDER_V : order;
                    iter_d  = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = (order_q != '0) ? S_RAND : S_DONE;
            end
            S_RAND: begin
                // Advancing on exit keeps rnd constant through SETTLE and STEP.
                lfsr_d = lfsr_next;
                if (SETTLE_CYC == 0) begin
                    state_d = S_STEP;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_STEP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STEP: begin
                iter_d  = iter_inc;
                state_d = (iter_inc == order_q) ? S_DONE : S_RAND;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every transition and freezes the datapath.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            lfsr_d  = lfsr_q;
            iter_d  = iter_q;
            order_d = order_q;
            cnt_d   = cnt_q;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign grid_clr = (state_q == S_CLEAR);
    assign grid_en  = (state_q == S_STEP);
    assign done     = (state_q == S_DONE);
    assign rnd      = lfsr_q[LFSR_W-1 -: NODES];
    assign iter     = iter_q;

endmodule

// File: tb/tb_arctic_seq.sv
// Scoreboard bench for arctic_seq: expected tie-break bytes and final iteration counts
// are queued when a run is launched and consumed as grid_en / done appear.
module tb_arctic_seq;

    localparam int SC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  order;
    logic        seed_load;
    logic [15:0] seed;
    logic        busy;
    logic        done;
    logic        grid_clr;
    logic        grid_en;
    logic [7:0]  rnd;
    logic [4:0]  iter;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int gen_cnt      = 0;
    int clr_cnt      = 0;
    int done_cnt     = 0;
    int last_gen     = -1;

    logic [7:0]  rnd_q[$];
    logic [4:0]  done_q[$];
    logic [15:0] model_lfsr;

    arctic_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .order     (order),
        .seed_load (seed_load),
        .seed      (seed),
        .busy      (busy),
        .done      (done),
        .grid_clr  (grid_clr),
        .grid_en   (grid_en),
        .rnd       (rnd),
        .iter      (iter)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        gen_cnt  = 0;
        clr_cnt  = 0;
        done_cnt = 0;
        last_gen = -1;
    endtask

    // Output monitor: consumes scoreboard entries as the DUT produces them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (grid_en) begin
                gen_cnt++;
                if (last_gen >= 0) check_val("gen_spacing", cyc - last_gen, 2 + SC);
                last_gen = cyc;
                if (rnd_q.size() == 0) check_val("gen_unexpected", 1, 0);
                else check_val("rnd_at_grid_en", rnd, rnd_q.pop_front());
            end
            if (grid_clr) clr_cnt++;
            if (done) begin
                done_cnt++;
                if (done_q.size() == 0) check_val("done_unexpected", 1, 0);
                else check_val("done_iter", iter, done_q.pop_front());
            end
        end
    end

    task automatic load_seed(input logic [15:0] s);
        seed      = s;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        model_lfsr = (s == 16'h0000) ? 16'hACE1 : s;
        check_val("seed_rnd", rnd, model_lfsr[15:8]);
        $display("[TB] seed_load seed=0x%04h rnd=0x%02h", s, rnd);
    endtask

    task automatic run_order(input int ord, input bit poke);
        int  eff;
        int  exp_cyc;
        int  n;
        bit  seen;
        eff = (ord > 16) ? 16 : ord;
        for (int i = 0; i < eff; i++) begin
            model_lfsr = lfsr_step(model_lfsr);
            rnd_q.push_back(model_lfsr[15:8]);
        end
        done_q.push_back(5'(eff));
        clear_counts();
        order = 5'(ord);
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_cyc = 1 + eff * (2 + SC);
        n    = 0;
        seen = 1'b0;
        while (n <= 400) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (poke && n == 3) begin
                start     = 1'b1;
                seed_load = 1'b1;
                seed      = 16'h1234;
                order     = 5'd7;
            end
            if (poke && n == 4) begin
                start     = 1'b0;
                seed_load = 1'b0;
            end
            tick();
            n++;
        end
        start     = 1'b0;
        seed_load = 1'b0;
        check_val("done_cycles", seen ? n : -1, exp_cyc);
        tick();
        check_val("idle_busy", busy, 0);
        check_val("final_iter", iter, eff);
        check_val("grid_en_count", gen_cnt, eff);
        check_val("grid_clr_count", clr_cnt, 1);
        check_val("done_count", done_cnt, 1);
        check_val("rnd_left", rnd_q.size(), 0);
        check_val("done_left", done_q.size(), 0);
        check_val("rnd_after_run", rnd, model_lfsr[15:8]);
        rnd_q.delete();
        done_q.delete();
        $display("[TB] run order=%0d eff=%0d done_after=%0d iter=%0d", ord, eff, n, iter);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        order     = '0;
        seed_load = 1'b0;
        seed      = '0;
        #2 rst_n = 1'b0;
        #1;
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_rnd", rnd, 8'hAC);
        check_val("reset_iter", iter, 0);
        tick();
        tick();
        rst_n = 1'b1;
        model_lfsr = 16'hACE1;
        tick();
        $display("[TB] reset released");

        load_seed(16'h0001);
        run_order(3, 1'b0);
        run_order(0, 1'b0);
        run_order(31, 1'b0);
        load_seed(16'h0000);
        run_order(2, 1'b1);

        // seed_load and start together in IDLE: seed wins, start ignored.
        clear_counts();
        seed      = 16'h00F0;
        seed_load = 1'b1;
        start     = 1'b1;
        order     = 5'd3;
        tick();
        seed_load = 1'b0;
        start     = 1'b0;
        model_lfsr = 16'h00F0;
        check_val("seed_start_busy", busy, 0);
        check_val("seed_start_rnd", rnd, 8'h00);
        tick();
        check_val("seed_start_clr", clr_cnt, 0);
        $display("[TB] seed_load+start rnd=0x%02h busy=%0d", rnd, busy);

        // Abort during the SETTLE of the second iteration.
        model_lfsr = lfsr_step(model_lfsr);
        rnd_q.push_back(model_lfsr[15:8]);
        model_lfsr = lfsr_step(model_lfsr);
        clear_counts();
        order = 5'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_busy", busy, 0);
        check_val("abort_iter", iter, 1);
        tick();
        tick();
        check_val("abort_no_done", done_cnt, 0);
        check_val("abort_gen_count", gen_cnt, 1);
        check_val("abort_rnd", rnd, model_lfsr[15:8]);
        check_val("abort_rnd_left", rnd_q.size(), 0);
        rnd_q.delete();
        $display("[TB] abort iter=%0d busy=%0d", iter, busy);
        run_order(3, 1'b0);

        // Asynchronous reset in the middle of a run.
        model_lfsr = lfsr_step(model_lfsr);
        rnd_q.push_back(model_lfsr[15:8]);
        clear_counts();
        order = 5'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy", busy, 0);
        check_val("midrst_done", done, 0);
        check_val("midrst_grid_en", grid_en, 0);
        check_val("midrst_grid_clr", grid_clr, 0);
        check_val("midrst_iter", iter, 0);
        check_val("midrst_rnd", rnd, 8'hAC);
        check_val("midrst_rnd_left", rnd_q.size(), 0);
        rnd_q.delete();
        done_q.delete();
        tick();
        rst_n = 1'b1;
        model_lfsr = 16'hACE1;
        tick();
        check_val("midrst_no_done", done_cnt, 0);
        $display("[TB] mid-run reset rnd=0x%02h", rnd);
        run_order(1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
